instr_encoder: RTL and testbench

// - Reverse of the control decoder: encodes mnemonic + operand fields into 32-bit instruction words.
// - Streams the words into instruction memory through a write port with a ready handshake.
// - Used by the boot/test loader to build programs in hardware.
// - Opcode lives in ins[31:26] and matches the decoder's opcode map exactly.

---
 rtl/instr_encoder.sv | 183 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: turns mnemonic + operand bundles into 32-bit instruction
// words and streams them into instruction memory over a ready/valid write
// port. Opcodes in ins[31:26] follow the control decoder's opcode map.
// Optional feature macro: ENC_CHECKSUM_EN adds a 32-bit XOR checksum output
// accumulated over every word actually written to memory.
module instr_encoder #(
    parameter int ADDR_W    = 32,
    parameter int COUNT_W   = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_mnem,
    input  logic [4:0]         in_rs,
    input  logic [4:0]         in_rt,
    input  logic [4:0]         in_rd,
    input  logic [15:0]        in_imm,
    input  logic [25:0]        in_target,
    input  logic               in_last,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [31:0]        imem_wdata,
    input  logic               imem_ready,
    output logic               busy,
    output logic               done,
    output logic               err_illegal,
`ifdef ENC_CHECKSUM_EN
    output logic [31:0]        checksum,
`endif
    output logic [COUNT_W-1:0] count
);

    // Mnemonic codes presented on in_mnem; 11..15 are illegal.
    typedef enum logic [3:0] {
        MN_ROLV = 4'd0,
        MN_RORV = 4'd1,
        MN_AND  = 4'd2,
        MN_NOR  = 4'd3,
        MN_NOT  = 4'd4,
        MN_NORI = 4'd5,
        MN_LW   = 4'd6,
        MN_SW   = 4'd7,
        MN_JR   = 4'd8,
        MN_JAL  = 4'd9,
        MN_BLEU = 4'd10
    } mnem_t;

    // Opcode map shared with the control decoder.
    localparam logic [5:0] OP_ROLV = 6'b000000;
    localparam logic [5:0] OP_RORV = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b100000;
    localparam logic [5:0] OP_NOR  = 6'b100110;
    localparam logic [5:0] OP_NOT  = 6'b000100;
    localparam logic [5:0] OP_NORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_JR   = 6'b001000;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BLEU = 6'b010000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state;
    logic        last_q;     // the word held in imem_wdata ends the session
    logic [31:0] enc_word;
    logic        enc_legal;

    // Encode the current bundle; illegal mnemonics only raise enc_legal=0.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        enc_word  = 32'b0;
        enc_legal = 1'b1;
        case (in_mnem)
            MN_ROLV: enc_word = {OP_ROLV, in_rs, in_rt, in_rd, 11'b0};
            MN_RORV: enc_word = {OP_RORV, in_rs, in_rt, in_rd, 11'b0};
            MN_AND:  enc_word = {OP_AND,  in_rs, in_rt, in_rd, 11'b0};
            MN_NOR:  enc_word = {OP_NOR,  in_rs, in_rt, in_rd, 11'b0};
            MN_NOT:  enc_word = {OP_NOT,  in_rs, 5'b0,  in_rd, 11'b0};
            MN_NORI: enc_word = {OP_NORI, in_rs, in_rt, in_imm};
            MN_LW:   enc_word = {OP_LW,   in_rs, in_rt, in_imm};
            MN_SW:   enc_word = {OP_SW,   in_rs, in_rt, in_imm};
            MN_BLEU: enc_word = {OP_BLEU, in_rs, in_rt, in_imm};
            MN_JR:   enc_word = {OP_JR,   in_rs, 21'b0};
            MN_JAL:  enc_word = {OP_JAL,  in_target};
            default: enc_legal = 1'b0;
        endcase
    end

    // Session FSM; every output is a register updated on the transition
    // into the state that owns it.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            imem_we     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            count       <= '0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            last_q      <= 1'b0;
`ifdef ENC_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        imem_addr   <= base_addr;
                        count       <= '0;
                        err_illegal <= 1'b0;
`ifdef ENC_CHECKSUM_EN
                        checksum    <= '0;
`endif
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid && in_ready) begin
                        last_q <= in_last;
                        if (enc_legal) begin
                            imem_wdata <= enc_word;
                            imem_we    <= 1'b1;
                            in_ready   <= 1'b0;
                            state      <= S_WRITE;
                        end else begin
                            // Illegal word is dropped; address and count stay put.
                            err_illegal <= 1'b1;
                            if (in_last) begin
                                in_ready <= 1'b0;
                                done     <= 1'b1;
                                state    <= S_DONE;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (imem_ready) begin
                        imem_we   <= 1'b0;
                        imem_addr <= imem_addr + ADDR_W'(ADDR_STEP);
                        if (count != '1) begin
                            count <= count + 1'b1;
                        end
`ifdef ENC_CHECKSUM_EN
                        checksum  <= checksum ^ imem_wdata;
`endif
                        if (last_q) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= S_ACCEPT;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized sessions for instr_encoder,
// checked against a table-driven instruction model and an address/count
// scoreboard kept in the bench.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_mnem;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;
    logic        busy, done, err_illegal;
    logic [15:0] count;
`ifdef ENC_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    instr_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mnem     (in_mnem),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .in_target   (in_target),
        .in_last     (in_last),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .imem_ready  (imem_ready),
        .busy        (busy),
        .done        (done),
        .err_illegal (err_illegal),
`ifdef ENC_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .count       (count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard for the current session.
    logic [31:0] exp_addr;
    int          exp_count;
    logic        exp_err;
    logic [31:0] exp_csum;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction model: opcode table plus field placement by format class.
    function automatic logic [31:0] model_word(input int m, input int rs, input int rt,
                                               input int rd, input int imm, input int tgt);
        int opc [11];
        longint unsigned w;
        opc = '{0, 2, 32, 38, 4, 14, 35, 43, 8, 3, 16};
        w = longint'(opc[m]) * 64'd67108864;              // op << 26
        if (m <= 4) begin                                   // register format
            w += longint'(rs) * 2097152 + longint'(rd) * 2048;
            if (m != 4) w += longint'(rt) * 65536;          // not: rt is zero
        end else if (m == 8) begin                          // jr
            w += longint'(rs) * 2097152;
        end else if (m == 9) begin                          // jal
            w += longint'(tgt);
        end else begin                                      // immediate format
            w += longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
        end
        return w[31:0];
    endfunction

    task automatic start_session(input logic [31:0] base);
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        exp_addr = base; exp_count = 0; exp_err = 1'b0; exp_csum = 32'h0;
        check("start_busy", busy, 1);
        check("start_in_ready", in_ready, 1);
        check("start_count", count, 0);
        check("start_err", err_illegal, 0);
        check("start_addr", imem_addr, base);
    endtask

    // Offer one bundle, hold imem_ready low for 'delay' edges, then complete.
    task automatic send(input int m, input int rs, input int rt, input int rd,
                        input int imm, input int tgt, input bit last,
                        input int delay, input bit poke_start);
        logic [31:0] w;
        int k;
        bit legal;
        legal = (m <= 10);
        w = legal ? model_word(m, rs, rt, rd, imm, tgt) : 32'h0;
        @(negedge clk);
        in_valid = 1'b1; in_mnem = 4'(m); in_rs = 5'(rs); in_rt = 5'(rt);
        in_rd = 5'(rd); in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        if (legal) begin
            check("we", imem_we, 1);
            check("in_ready_write", in_ready, 0);
            check("addr", imem_addr, exp_addr);
            check("wdata", imem_wdata, w);
            for (int d = 0; d < delay; d++) begin
                start = poke_start;
                base_addr = 32'hDEAD_0000;
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
                check("hold_we", imem_we, 1);
                check("hold_addr", imem_addr, exp_addr);
                check("hold_wdata", imem_wdata, w);
                check("hold_in_ready", in_ready, 0);
                check("hold_count", count, 64'(exp_count));
            end
            imem_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            imem_ready = 1'b0;
            exp_addr  = exp_addr + 32'd4;
            exp_count = (exp_count == 65535) ? 65535 : exp_count + 1;
            exp_csum  = exp_csum ^ w;
            check("we_after", imem_we, 0);
        end else begin
            exp_err = 1'b1;
            check("illegal_no_we", imem_we, 0);
            check("illegal_err", err_illegal, 1);
        end
        if (last) begin
            check("done_pulse", done, 1);
            check("done_busy", busy, 1);
            @(negedge clk);
            check("done_clear", done, 0);
            check("idle_busy", busy, 0);
            check("end_count", count, 64'(exp_count));
            check("end_err", err_illegal, exp_err);
            check("end_addr", imem_addr, exp_addr);
`ifdef ENC_CHECKSUM_EN
            check("checksum", checksum, exp_csum);
`endif
        end else begin
            check("next_in_ready", in_ready, 1);
            check("mid_count", count, 64'(exp_count));
            check("mid_done", done, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = 32'h0; in_valid = 1'b0;
        in_mnem = 4'h0; in_rs = 5'h0; in_rt = 5'h0; in_rd = 5'h0;
        in_imm = 16'h0; in_target = 26'h0; in_last = 1'b0; imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state.
        check("rst_in_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_illegal, 0);
        check("rst_count", count, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);

        // 1: single and word.
        start_session(32'h100);
        check("model_and", model_word(2, 1, 2, 3, 0, 0), 32'h8022_1800);
        send(2, 1, 2, 3, 0, 0, 1'b1, 0, 1'b0);

        // 2: lw then jal.
        start_session(32'h2000);
        check("model_lw", model_word(6, 29, 8, 0, 16'hFFFC, 0), 32'h8FA8_FFFC);
        check("model_jal", model_word(9, 0, 0, 0, 0, 26'h40), 32'h0C00_0040);
        send(6, 29, 8, 0, 16'hFFFC, 0, 1'b0, 0, 1'b0);
        send(9, 0, 0, 0, 0, 26'h40, 1'b1, 0, 1'b0);

        // 3: memory stalls three edges during WRITE.
        start_session(32'h300);
        send(10, 7, 9, 0, 16'h1234, 0, 1'b1, 3, 1'b0);

        // 4: illegal mnemonic, then nor.
        start_session(32'h400);
        send(12, 1, 1, 1, 0, 0, 1'b0, 0, 1'b0);
        send(3, 4, 5, 6, 0, 0, 1'b1, 0, 1'b0);

        // 5: address wrap; start pulsed mid-session is ignored.
        start_session(32'hFFFF_FFFC);
        send(4, 3, 31, 2, 0, 0, 1'b0, 2, 1'b1);
        check("wrap_addr", imem_addr, 32'h0);
        send(8, 17, 0, 0, 0, 0, 1'b1, 1, 1'b1);

        // 6: reset while a write is pending.
        start_session(32'h600);
        @(negedge clk);
        in_valid = 1'b1; in_mnem = 4'd7; in_rs = 5'd2; in_rt = 5'd3;
        in_imm = 16'h0010; in_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_we", imem_we, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_we", imem_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_addr", imem_addr, 0);
        check("mid_rst_wdata", imem_wdata, 0);
`ifdef ENC_CHECKSUM_EN
        check("mid_rst_checksum", checksum, 0);
`endif
        @(negedge clk);
        check("post_rst_idle_we", imem_we, 0);

        // Randomized sessions.
        for (int s = 0; s < 8; s++) begin
            int nb;
            start_session($urandom);
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                send($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 65535),
                     $urandom_range(0, 26'h3FF_FFFF), (b == nb - 1),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
